icache_fetch: RTL and testbench

// - Instruction-side responder to main_controller.
// - Accepts fetch requests (fetch_enable, PC) from the controller.
// - Returns fetch_valid/instr_fetch from a direct-mapped instruction cache.
// - Refills misses from a word-wide req/ack memory port; sits between core and instruction memory.

---
 rtl/icache_fetch.sv | 171 +++++++++++++++++
 tb/tb_icache_fetch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped instruction cache between main_controller and a
// word-wide req/ack instruction memory. Misses refill a whole line in order
// (word 0 first) and return the requested word once the line is complete.
// Optional build macro ICACHE_STATS_EN adds hit_count/miss_count ports.
module icache_fetch #(
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic        fetch_enable,
  input  logic [31:0] PC,
  input  logic        flush,
  output logic        fetch_valid,
  output logic [31:0] instr_fetch,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OFF = $clog2(WORDS_PER_LINE);
  localparam int IDX = $clog2(NUM_LINES);
  localparam int TAG = 30 - OFF - IDX;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_RESPOND} state_t;

  state_t                r_state;
  logic [31:0]           r_req_addr;
  logic [OFF-1:0]        r_wc;
  logic [31:0]           r_cap;
  logic [31:0]           r_last;
  logic                  r_flush_pend;
  logic                  r_mem_req;
  logic                  r_busy;
  logic [NUM_LINES-1:0]  r_valid;
  logic [31:0]           r_data [NUM_LINES*WORDS_PER_LINE];
  logic [TAG-1:0]        r_tag  [NUM_LINES];

  logic [IDX-1:0]        w_idx;
  logic [OFF-1:0]        w_off;
  logic [TAG-1:0]        w_tag;
  logic [IDX+OFF-1:0]    w_rd_sel;
  logic [IDX+OFF-1:0]    w_wr_sel;
  logic                  w_hit;
  logic                  w_ack;
  logic                  w_last;
  logic                  w_fv;
  logic [31:0]           w_out;
  logic                  w_unused_lsb;

  assign w_idx        = r_req_addr[OFF+IDX+1:OFF+2];
  assign w_off        = r_req_addr[OFF+1:2];
  assign w_tag        = r_req_addr[31:OFF+IDX+2];
  assign w_rd_sel     = {w_idx, w_off};
  assign w_wr_sel     = {w_idx, r_wc};
  assign w_unused_lsb = ^r_req_addr[1:0];

  // A same-cycle flush turns a lookup hit into a miss.
  assign w_hit  = (r_state == S_LOOKUP) && r_valid[w_idx] &&
                  (r_tag[w_idx] == w_tag) && !flush;
  assign w_ack  = (r_state == S_REFILL) && mem_ack;
  assign w_last = w_ack && (&r_wc);
  assign w_fv   = w_hit || (r_state == S_RESPOND);
  assign w_out  = (r_state == S_RESPOND) ? r_cap : r_data[w_rd_sel];

  assign fetch_valid = w_fv;
  assign instr_fetch = w_fv ? w_out : r_last;
  assign mem_req     = r_mem_req;
  assign mem_addr    = {r_req_addr[31:OFF+2], r_wc, 2'b00};
  assign busy        = r_busy;

  // Control FSM: accept, lookup, in-order line refill, single-cycle respond.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_req_addr   <= '0;
      r_wc         <= '0;
      r_cap        <= '0;
      r_flush_pend <= 1'b0;
      r_mem_req    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fetch_enable) begin
            r_req_addr <= PC;
            r_state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            if (fetch_enable) r_req_addr <= PC;
            else              r_state    <= S_IDLE;
          end else begin
            r_state   <= S_REFILL;
            r_wc      <= '0;
            r_mem_req <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_REFILL: begin
          if (flush) r_flush_pend <= 1'b1;
          if (mem_ack) begin
            if (r_wc == w_off) r_cap <= mem_rdata;
            r_wc <= r_wc + 1'b1;
            if (&r_wc) begin
              r_state      <= S_RESPOND;
              r_mem_req    <= 1'b0;
              r_flush_pend <= 1'b0;
            end
          end
        end
        S_RESPOND: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Valid bits: flush wipes everything; a clean refill validates its line.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else if (w_last && !r_flush_pend) begin
      r_valid[w_idx] <= 1'b1;
    end
  end

  // Data and tag arrays are written only by refill; no reset needed.
  always_ff @(posedge CLK) begin
    if (w_ack)  r_data[w_wr_sel] <= mem_rdata;
    if (w_last) r_tag[w_idx]     <= w_tag;
  end

  // Remember the last delivered word so instr_fetch holds between pulses.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn)   r_last <= '0;
    else if (w_fv) r_last <= w_out;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // One count per lookup cycle; flush-forced misses land in miss_count.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else       r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: cold miss, hit stream, conflict, flush
// during refill, reset mid-refill, zero-wait memory, address wrap, flush
// priority over a lookup hit. Inputs driven and outputs sampled at negedge.
module tb_icache_fetch;

  localparam logic [31:0] PAT = 32'hA5A5A5A5;

  logic        CLK;
  logic        resetn;
  logic        fetch_enable;
  logic [31:0] PC;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] instr_fetch;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_fetch #(.NUM_LINES(64), .WORDS_PER_LINE(4)) dut (
    .CLK(CLK), .resetn(resetn), .fetch_enable(fetch_enable), .PC(PC),
    .flush(flush), .fetch_valid(fetch_valid), .instr_fetch(instr_fetch),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          lat      = 2;
  int          wcnt     = 0;
  int          acks     = 0;
  logic [31:0] aq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge and play the memory side for this cycle.
  task automatic cyc();
    @(negedge CLK);
    if (lat == 0) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_addr ^ PAT;
      if (mem_req) begin
        aq.push_back(mem_addr);
        acks++;
      end
    end else begin
      mem_ack = 1'b0;
      if (mem_req) begin
        if (wcnt == lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_addr ^ PAT;
          aq.push_back(mem_addr);
          acks++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
  endtask

  // Step with fetch_enable low until fetch_valid; optionally pulse flush at wc==1.
  task automatic run_fv(input string tag, input int maxc, input bit fl,
                        output int n, output logic [31:0] d, output int rq);
    logic got;
    bit   fdone;
    got = 1'b0; fdone = 1'b0; n = 0; rq = 0; d = 'x;
    for (int i = 0; i < maxc; i++) begin
      cyc();
      fetch_enable = 1'b0;
      flush = fl && (acks == 1) && !mem_ack && !fdone;
      if (flush) fdone = 1'b1;
      #1;
      n++;
      if (mem_req) rq++;
      if (fetch_valid) begin
        d   = instr_fetch;
        got = 1'b1;
        break;
      end
    end
    flush = 1'b0;
    chk({tag, "_seen"}, {31'd0, got}, 32'd1);
  endtask

  // Issue one fetch in an idle cycle, then report the lookup cycle's fetch_valid.
  task automatic issue(input logic [31:0] pc, input logic fl_lookup, output logic fv, output logic [31:0] d);
    cyc();
    fetch_enable = 1'b1; PC = pc;
    cyc();
    fetch_enable = 1'b0; flush = fl_lookup;
    #1;
    fv = fetch_valid; d = instr_fetch;
  endtask

  int          n, rq;
  logic [31:0] d;
  logic        fv;
  bit          hit2;

  initial begin
    resetn = 1'b0; fetch_enable = 1'b0; PC = '0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_instr_fetch", instr_fetch, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge CLK);
    resetn = 1'b1;

    // Cold miss, memory acks 2 cycles after each request
    cyc();
    fetch_enable = 1'b1; PC = 32'h1000;
    #1;
    chk("cold_idle_fv", {31'd0, fetch_valid}, 32'd0);
    aq.delete(); acks = 0;
    run_fv("cold", 40, 1'b0, n, d, rq);
    chk("cold_latency", n, 32'd14);
    chk("cold_req_cycles", rq, 32'd12);
    chk("cold_data", d, 32'hA5A5B5A5);
    chk("cold_nwords", aq.size(), 32'd4);
    chk("cold_addr0", aq[0], 32'h1000);
    chk("cold_addr1", aq[1], 32'h1004);
    chk("cold_addr2", aq[2], 32'h1008);
    chk("cold_addr3", aq[3], 32'h100C);
    cyc(); #1;
    chk("cold_one_pulse", {31'd0, fetch_valid}, 32'd0);
    chk("cold_busy_done", {31'd0, busy}, 32'd0);
    chk("cold_hold", instr_fetch, 32'hA5A5B5A5);

    // Hit stream at one instruction per cycle
    cyc(); fetch_enable = 1'b1; PC = 32'h1004;
    cyc(); PC = 32'h1008; #1;
    chk("hs0_fv", {31'd0, fetch_valid}, 32'd1);
    chk("hs0_data", instr_fetch, 32'hA5A5B5A1);
    cyc(); PC = 32'h100C; #1;
    chk("hs1_fv", {31'd0, fetch_valid}, 32'd1);
    chk("hs1_data", instr_fetch, 32'hA5A5B5AD);
    chk("hs1_mem_req", {31'd0, mem_req}, 32'd0);
    cyc(); fetch_enable = 1'b0; #1;
    chk("hs2_fv", {31'd0, fetch_valid}, 32'd1);
    chk("hs2_data", instr_fetch, 32'hA5A5B5A9);
    cyc(); #1;
    chk("hs_end_fv", {31'd0, fetch_valid}, 32'd0);
    chk("hs_hold", instr_fetch, 32'hA5A5B5A9);
    chk("hs_mem_req", {31'd0, mem_req}, 32'd0);

    // Conflict: 0x1400 maps onto the 0x1000 line
    cyc(); fetch_enable = 1'b1; PC = 32'h1000;
    cyc(); PC = 32'h1400; #1;
    chk("cf_hit_fv", {31'd0, fetch_valid}, 32'd1);
    chk("cf_hit_data", instr_fetch, 32'hA5A5B5A5);
    cyc(); fetch_enable = 1'b0; #1;
    chk("cf_miss_fv", {31'd0, fetch_valid}, 32'd0);
    aq.delete(); acks = 0;
    run_fv("cf", 40, 1'b0, n, d, rq);
    chk("cf_data", d, 32'hA5A5B1A5);
    chk("cf_addr0", aq[0], 32'h1400);
    chk("cf_addr3", aq[3], 32'h140C);
    issue(32'h1000, 1'b0, fv, d);
    chk("cf_remiss", {31'd0, fv}, 32'd0);
    run_fv("cf_re", 40, 1'b0, n, d, rq);
    chk("cf_re_data", d, 32'hA5A5B5A5);

    // Flush during refill: word returned once, line left invalid
    issue(32'h2008, 1'b0, fv, d);
    chk("fl_miss", {31'd0, fv}, 32'd0);
    acks = 0;
    run_fv("fl", 40, 1'b1, n, d, rq);
    chk("fl_data", d, 32'hA5A585AD);
    cyc(); #1;
    chk("fl_once", {31'd0, fetch_valid}, 32'd0);
    issue(32'h2008, 1'b0, fv, d);
    chk("fl_remiss", {31'd0, fv}, 32'd0);
    run_fv("fl_re", 40, 1'b0, n, d, rq);
    chk("fl_re_data", d, 32'hA5A585AD);
    issue(32'h2008, 1'b0, fv, d);
    chk("fl_post_hit", {31'd0, fv}, 32'd1);
    chk("fl_post_data", d, 32'hA5A585AD);

    // Reset mid-refill at wc==2
    issue(32'h1000, 1'b0, fv, d);
    chk("rm_miss", {31'd0, fv}, 32'd0);
    acks = 0; hit2 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(); #1;
      if (acks == 2 && !mem_ack) begin
        hit2 = 1'b1;
        resetn = 1'b0;
        #1;
        chk("rm_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rm_busy", {31'd0, busy}, 32'd0);
        break;
      end
    end
    chk("rm_reached_wc2", {31'd0, hit2}, 32'd1);
    cyc(); resetn = 1'b1; wcnt = 0; mem_ack = 1'b0;
    issue(32'h1000, 1'b0, fv, d);
    chk("rm_after_miss", {31'd0, fv}, 32'd0);
    run_fv("rm_re", 40, 1'b0, n, d, rq);
    chk("rm_re_data", d, 32'hA5A5B5A5);

    // Zero-wait memory from a fresh reset
    cyc(); resetn = 1'b0;
    cyc(); resetn = 1'b1; lat = 0;
    cyc(); fetch_enable = 1'b1; PC = 32'h1000;
    aq.delete();
    run_fv("zw", 20, 1'b0, n, d, rq);
    chk("zw_latency", n, 32'd6);
    chk("zw_req_cycles", rq, 32'd4);
    chk("zw_data", d, 32'hA5A5B5A5);
`ifdef ICACHE_STATS_EN
    chk("zw_miss_count", miss_count, 32'd1);
    chk("zw_hit_count", hit_count, 32'd0);
`endif

    // Address wrap at the top of memory
    cyc(); fetch_enable = 1'b1; PC = 32'hFFFFFFFC;
    aq.delete();
    run_fv("wr", 20, 1'b0, n, d, rq);
    chk("wr_data", d, 32'h5A5A5A59);
    chk("wr_addr0", aq[0], 32'hFFFFFFF0);
    chk("wr_addr3", aq[3], 32'hFFFFFFFC);
    issue(32'hFFFFFFF0, 1'b0, fv, d);
    chk("wr_hit_fv", {31'd0, fv}, 32'd1);
    chk("wr_hit_data", d, 32'h5A5A5A55);

    // Flush in the lookup cycle beats a hit
    issue(32'hFFFFFFF0, 1'b1, fv, d);
    chk("fp_fv", {31'd0, fv}, 32'd0);
    run_fv("fp", 20, 1'b0, n, d, rq);
    chk("fp_data", d, 32'h5A5A5A55);
`ifdef ICACHE_STATS_EN
    chk("end_miss_count", miss_count, 32'd3);
    chk("end_hit_count", hit_count, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
